// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared RV32I decode constants: base opcodes and ResultSrc encodings used by the
// decoder and the ID/EX register.
package id_ex_pipe_reg_pkg;

   localparam int unsigned OP_W = 7;

   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

   localparam int unsigned RESULT_SRC_W = 2;

   localparam logic [RESULT_SRC_W-1:0] RESULT_ALU = 2'b00;
   localparam logic [RESULT_SRC_W-1:0] RESULT_MEM = 2'b01;
   localparam logic [RESULT_SRC_W-1:0] RESULT_PC4 = 2'b10;
   localparam logic [RESULT_SRC_W-1:0] RESULT_IMM = 2'b11;

endpackage

// File: rtl/id_ex_pipe_reg_opcode_legal.sv
// Opcode classifier: flags legal RV32I base opcodes and the classes whose controls
// the ID/EX register re-derives instead of trusting the decoder.
module id_ex_pipe_reg_opcode_legal
   import id_ex_pipe_reg_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   output logic            legal_c,
   output logic            is_store_c,
   output logic            is_branch_c,
   output logic            is_jal_c,
   output logic            is_jalr_c,
   output logic            is_utype_c
);

   always_comb begin
      legal_c     = 1'b0;
      is_store_c  = 1'b0;
      is_branch_c = 1'b0;
      is_jal_c    = 1'b0;
      is_jalr_c   = 1'b0;
      is_utype_c  = 1'b0;
      // Unknown or X opcodes fall to default and read as illegal.
      case (op_i)
         OP_LOAD, OP_RTYPE, OP_ITYPE: legal_c = 1'b1;
         OP_STORE:  begin legal_c = 1'b1; is_store_c  = 1'b1; end
         OP_BRANCH: begin legal_c = 1'b1; is_branch_c = 1'b1; end
         OP_JAL:    begin legal_c = 1'b1; is_jal_c    = 1'b1; end
         OP_JALR:   begin legal_c = 1'b1; is_jalr_c   = 1'b1; end
         OP_LUI, OP_AUIPC: begin legal_c = 1'b1; is_utype_c = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, illegal-opcode squash, control
// sanitisation and a saturating bubble counter.
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALUCTL_W = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    StallE,
   input  logic                    FlushE,
   input  logic                    ValidD,
   input  logic [OP_W-1:0]         OpD,
   input  logic                    RegWriteD,
   input  logic [RESULT_SRC_W-1:0] ResultSrcD,
   input  logic                    MemWriteD,
   input  logic                    JumpD,
   input  logic                    BranchD,
   input  logic                    ALUSrcD,
   input  logic                    JalrD,
   input  logic [ALUCTL_W-1:0]     ALUControlD,
   input  logic [2:0]              Funct3D,
   input  logic [XLEN-1:0]         RD1D,
   input  logic [XLEN-1:0]         RD2D,
   input  logic [XLEN-1:0]         ImmExtD,
   input  logic [XLEN-1:0]         PCD,
   input  logic [XLEN-1:0]         PCPlus4D,
   input  logic [4:0]              Rs1D,
   input  logic [4:0]              Rs2D,
   input  logic [4:0]              RdD,
   output logic                    RegWriteE,
   output logic [RESULT_SRC_W-1:0] ResultSrcE,
   output logic                    MemWriteE,
   output logic                    JumpE,
   output logic                    BranchE,
   output logic                    ALUSrcE,
   output logic                    JalrE,
   output logic [ALUCTL_W-1:0]     ALUControlE,
   output logic [2:0]              Funct3E,
   output logic [XLEN-1:0]         RD1E,
   output logic [XLEN-1:0]         RD2E,
   output logic [XLEN-1:0]         ImmExtE,
   output logic [XLEN-1:0]         PCE,
   output logic [XLEN-1:0]         PCPlus4E,
   output logic [4:0]              Rs1E,
   output logic [4:0]              Rs2E,
   output logic [4:0]              RdE,
   output logic                    ValidE,
   output logic                    IllegalE,
   output logic [CNT_W-1:0]        BubbleCnt
);

   logic legal, is_store, is_branch, is_jal, is_jalr, is_utype;

   id_ex_pipe_reg_opcode_legal u_opcode_legal (
      .op_i        (OpD),
      .legal_c     (legal),
      .is_store_c  (is_store),
      .is_branch_c (is_branch),
      .is_jal_c    (is_jal),
      .is_jalr_c   (is_jalr),
      .is_utype_c  (is_utype)
   );

   // Decoder store/jump/branch flags are re-derived from the opcode, never trusted.
   logic unused_dec_ctl;
   assign unused_dec_ctl = ^{MemWriteD, JumpD, BranchD, JalrD};

   logic                    reg_write_q, reg_write_d;
   logic [RESULT_SRC_W-1:0] result_src_q, result_src_d;
   logic                    mem_write_q, mem_write_d;
   logic                    jump_q, jump_d;
   logic                    branch_q, branch_d;
   logic                    alu_src_q, alu_src_d;
   logic                    jalr_q, jalr_d;
   logic [ALUCTL_W-1:0]     alu_ctl_q, alu_ctl_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [XLEN-1:0]         rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [XLEN-1:0]         pc_q, pc_d, pc4_q, pc4_d;
   logic [4:0]              rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                    valid_q, valid_d;
   logic                    illegal_q, illegal_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   always_comb begin
      reg_write_d  = reg_write_q;
      result_src_d = result_src_q;
      mem_write_d  = mem_write_q;
      jump_d       = jump_q;
      branch_d     = branch_q;
      alu_src_d    = alu_src_q;
      jalr_d       = jalr_q;
      alu_ctl_d    = alu_ctl_q;
      funct3_d     = funct3_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      imm_d        = imm_q;
      pc_d         = pc_q;
      pc4_d        = pc4_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      valid_d      = valid_q;
      illegal_d    = illegal_q;
      cnt_d        = cnt_q;
      // Any non-stalled edge starts from an all-zero bubble, then fills in what applies.
      if (FlushE || !StallE) begin
         reg_write_d  = 1'b0;
         result_src_d = '0;
         mem_write_d  = 1'b0;
         jump_d       = 1'b0;
         branch_d     = 1'b0;
         alu_src_d    = 1'b0;
         jalr_d       = 1'b0;
         alu_ctl_d    = '0;
         funct3_d     = '0;
         rd1_d        = '0;
         rd2_d        = '0;
         imm_d        = '0;
         pc_d         = '0;
         pc4_d        = '0;
         rs1_d        = '0;
         rs2_d        = '0;
         rd_d         = '0;
         valid_d      = 1'b0;
         illegal_d    = 1'b0;
         if (FlushE || !ValidD || !legal) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
         end
         if (!FlushE && ValidD && !legal) begin
            illegal_d = 1'b1;
            pc_d      = PCD;
         end else if (!FlushE && ValidD && legal) begin
            reg_write_d  = RegWriteD & (RdD != 5'd0);
            result_src_d = ResultSrcD;
            mem_write_d  = is_store;
            jump_d       = is_jal | is_jalr;
            branch_d     = is_branch;
            alu_src_d    = ALUSrcD & ~is_utype;
            jalr_d       = is_jalr;
            alu_ctl_d    = ALUControlD;
            funct3_d     = Funct3D;
            rd1_d        = RD1D;
            rd2_d        = RD2D;
            imm_d        = ImmExtD;
            pc_d         = PCD;
            pc4_d        = PCPlus4D;
            rs1_d        = Rs1D;
            rs2_d        = Rs2D;
            rd_d         = RdD;
            valid_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         result_src_q <= '0;
         mem_write_q  <= 1'b0;
         jump_q       <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         jalr_q       <= 1'b0;
         alu_ctl_q    <= '0;
         funct3_q     <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         pc_q         <= '0;
         pc4_q        <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         valid_q      <= 1'b0;
         illegal_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         mem_write_q  <= mem_write_d;
         jump_q       <= jump_d;
         branch_q     <= branch_d;
         alu_src_q    <= alu_src_d;
         jalr_q       <= jalr_d;
         alu_ctl_q    <= alu_ctl_d;
         funct3_q     <= funct3_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         valid_q      <= valid_d;
         illegal_q    <= illegal_d;
         cnt_q        <= cnt_d;
      end
   end

   assign RegWriteE   = reg_write_q;
   assign ResultSrcE  = result_src_q;
   assign MemWriteE   = mem_write_q;
   assign JumpE       = jump_q;
   assign BranchE     = branch_q;
   assign ALUSrcE     = alu_src_q;
   assign JalrE       = jalr_q;
   assign ALUControlE = alu_ctl_q;
   assign Funct3E     = funct3_q;
   assign RD1E        = rd1_q;
   assign RD2E        = rd2_q;
   assign ImmExtE     = imm_q;
   assign PCE         = pc_q;
   assign PCPlus4E    = pc4_q;
   assign Rs1E        = rs1_q;
   assign Rs2E        = rs2_q;
   assign RdE         = rd_q;
   assign ValidE      = valid_q;
   assign IllegalE    = illegal_q;
   assign BubbleCnt   = cnt_q;

endmodule
